// File: rtl/stage_mem_pkg.sv
// Shared types for the memory stage: FSM states, access size encoding,
// the mem-to-wb payload, and small address/strobe helpers.
package stage_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } mem_size_e;

  typedef struct packed {
    logic [63:0] result;
    logic [63:0] readdata;
  } mem_wb_t;

  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    logic mis;
    case (mem_size_e'(size))
      SZ_B:    mis = 1'b0;
      SZ_H:    mis = off[0];
      SZ_W:    mis = |off[1:0];
      SZ_D:    mis = |off;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte-lane mask of 2^size ones placed at the access offset.
  function automatic logic [7:0] strb_mask(input logic [2:0] off, input logic [1:0] size);
    logic [7:0] base;
    case (mem_size_e'(size))
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      SZ_D:    base = 8'hFF;
      default: base = 8'h00;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/stage_mem_load_align.sv
// Load data extraction: shifts the bus word down to the access offset,
// keeps the access width and sign- or zero-extends to 64 bits.
module load_align
  import stage_mem_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [63:0] result_o
);

  logic [63:0] shifted_s;

  assign shifted_s = rdata_i >> {offset_i, 3'b000};

  // Width select and extension; doublewords ignore the unsigned flag.
  always_comb begin
    result_o = 64'd0;
    case (mem_size_e'(size_i))
      SZ_B:    result_o = {{56{~unsigned_i & shifted_s[7]}},  shifted_s[7:0]};
      SZ_H:    result_o = {{48{~unsigned_i & shifted_s[15]}}, shifted_s[15:0]};
      SZ_W:    result_o = {{32{~unsigned_i & shifted_s[31]}}, shifted_s[31:0]};
      SZ_D:    result_o = shifted_s;
      default: result_o = shifted_s;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// Pipeline memory stage: issues one data-bus request per aligned load/store,
// waits for its response and hands aligned load data to writeback.
module stage_mem
  import stage_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_flush,
  input  logic        mem_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [63:0] exe_result,
  input  logic [63:0] exe_rs2,
  output logic        mem_ready,
  output logic        mem_misalign,
  output logic [63:0] wb_result,
  output logic [63:0] wb_readdata,
  output logic        dbus_req_valid,
  input  logic        dbus_req_ready,
  output logic [63:0] dbus_addr,
  output logic        dbus_we,
  output logic [7:0]  dbus_wstrb,
  output logic [63:0] dbus_wdata,
  input  logic        dbus_resp_valid,
  input  logic [63:0] dbus_rdata
);

  mem_state_e  state_q, state_d;
  logic        req_valid_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        we_q;

  logic        access_s;
  logic        misalign_s;
  logic        start_s;
  logic        capture_s;
  logic [63:0] load_data_s;
  mem_wb_t     wb_s;

  assign access_s   = mem_valid & (mem_read | mem_write);
  assign misalign_s = access_s & is_misaligned(exe_result[2:0], mem_size);
  assign start_s    = (state_q == ST_IDLE) & access_s & ~misalign_s & ~mem_flush;
  // A response that coincides with a flush is dropped, never captured.
  assign capture_s  = (state_q == ST_WAIT) & dbus_resp_valid & ~mem_flush;

  // Next-state and retire decode.
  always_comb begin
    state_d   = state_q;
    mem_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mem_ready = ~start_s;
        if (start_s) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dbus_req_ready) begin
          state_d = mem_flush ? ST_DRAIN : ST_WAIT;
        end else if (mem_flush) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (dbus_resp_valid) begin
          state_d = mem_flush ? ST_IDLE : ST_DONE;
        end else if (mem_flush) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        mem_ready = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_DRAIN: begin
        if (dbus_resp_valid) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, request flag, latched access controls and captured response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_valid_q <= 1'b0;
      addr_q      <= 64'd0;
      wdata_q     <= 64'd0;
      rdata_q     <= 64'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= (state_d == ST_REQ);
      if (start_s) begin
        addr_q  <= exe_result;
        wdata_q <= exe_rs2;
        size_q  <= mem_size;
        uns_q   <= mem_unsigned;
        we_q    <= mem_write;
      end
      if (capture_s) begin
        rdata_q <= dbus_rdata;
      end
    end
  end

  // Bus fields come only from the latched copies so they stay stable in REQ.
  assign dbus_req_valid = req_valid_q;
  assign dbus_addr      = {addr_q[63:3], 3'b000};
  assign dbus_we        = we_q;
  assign dbus_wstrb     = strb_mask(addr_q[2:0], size_q);
  assign dbus_wdata     = wdata_q << {addr_q[2:0], 3'b000};

  assign mem_misalign   = (state_q == ST_IDLE) & misalign_s;

  load_align u_load_align (
    .rdata_i    (rdata_q),
    .offset_i   (addr_q[2:0]),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .result_o   (load_data_s)
  );

  assign wb_s.result   = exe_result;
  assign wb_s.readdata = ((state_q == ST_DONE) && !we_q) ? load_data_s : 64'd0;

  assign wb_result   = wb_s.result;
  assign wb_readdata = wb_s.readdata;

endmodule

// File: tb/tb_stage_mem.sv
// Directed and randomized checks of stage_mem against a byte-level
// reference model of the load/store rules.
module tb_stage_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_flush, mem_valid, mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size;
  logic [63:0] exe_result, exe_rs2;
  logic        mem_ready, mem_misalign;
  logic [63:0] wb_result, wb_readdata;
  logic        dbus_req_valid, dbus_req_ready, dbus_we, dbus_resp_valid;
  logic [63:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [7:0]  dbus_wstrb;

  int n_cmp  = 0;
  int n_fail = 0;

  stage_mem dut (
    .clk(clk), .rst(rst), .mem_flush(mem_flush), .mem_valid(mem_valid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .exe_result(exe_result), .exe_rs2(exe_rs2),
    .mem_ready(mem_ready), .mem_misalign(mem_misalign), .wb_result(wb_result),
    .wb_readdata(wb_readdata), .dbus_req_valid(dbus_req_valid),
    .dbus_req_ready(dbus_req_ready), .dbus_addr(dbus_addr), .dbus_we(dbus_we),
    .dbus_wstrb(dbus_wstrb), .dbus_wdata(dbus_wdata),
    .dbus_resp_valid(dbus_resp_valid), .dbus_rdata(dbus_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic ref_misalign(input logic [63:0] addr, input logic [1:0] sz);
    return (addr % (64'd1 << sz)) != 64'd0;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input logic [63:0] addr,
                                           input logic [1:0] sz, input logic uns);
    logic [63:0] v;
    int off, nb;
    v   = 64'd0;
    off = int'(addr % 64'd8);
    nb  = 1 << sz;
    for (int b = 0; b < nb; b++)
      if (off + b < 8) v[8*b +: 8] = rdata[8*(off+b) +: 8];
    if (!uns && nb < 8 && v[8*nb-1])
      for (int b = nb; b < 8; b++) v[8*b +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] ref_strb(input logic [63:0] addr, input logic [1:0] sz);
    logic [7:0] s;
    int off;
    s   = 8'h00;
    off = int'(addr % 64'd8);
    for (int b = 0; b < (1 << sz); b++)
      if (off + b < 8) s[off+b] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] addr, input logic [63:0] rs2);
    logic [63:0] w;
    int off;
    w   = 64'd0;
    off = int'(addr % 64'd8);
    for (int b = 0; b + off < 8; b++) w[8*(off+b) +: 8] = rs2[8*b +: 8];
    return w;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    mem_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_flush = 1'b0;
    dbus_req_ready = 1'b0; dbus_resp_valid = 1'b0;
  endtask

  task automatic present(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] rs2);
    mem_valid = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz;
    mem_unsigned = uns; exe_result = addr; exe_rs2 = rs2; mem_flush = 1'b0;
  endtask

  // One full access; ready is withheld rdy_dly cycles, response comes resp_dly cycles late.
  task automatic run_access(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [63:0] addr, input logic [63:0] rs2,
                            input logic [63:0] rdata, input int rdy_dly, input int resp_dly);
    logic mis;
    mis = ref_misalign(addr, sz);
    present(rd, wr, sz, uns, addr, rs2);
    #1;
    check({tag, "/misalign"}, mem_misalign, mis);
    check({tag, "/wb_result"}, wb_result, addr);
    if (mis) begin
      check({tag, "/mis_ready"}, mem_ready, 64'd1);
      check({tag, "/mis_noreq"}, dbus_req_valid, 64'd0);
      tick();
      go_idle();
      #1;
      check({tag, "/mis_noreq_after"}, dbus_req_valid, 64'd0);
      return;
    end
    check({tag, "/issue_ready"}, mem_ready, 64'd0);
    tick();
    for (int i = 0; i <= rdy_dly; i++) begin
      dbus_req_ready = (i == rdy_dly);
      #1;
      check({tag, "/req_valid"}, dbus_req_valid, 64'd1);
      check({tag, "/req_addr"}, dbus_addr, addr & ~64'd7);
      check({tag, "/req_we"}, dbus_we, wr);
      check({tag, "/req_wstrb"}, dbus_wstrb, ref_strb(addr, sz));
      if (wr) check({tag, "/req_wdata"}, dbus_wdata, ref_wdata(addr, rs2));
      check({tag, "/req_ready"}, mem_ready, 64'd0);
      tick();
    end
    dbus_req_ready = 1'b0;
    for (int j = 0; j <= resp_dly; j++) begin
      dbus_resp_valid = (j == resp_dly);
      dbus_rdata = (j == resp_dly) ? rdata : {$urandom, $urandom};
      #1;
      check({tag, "/wait_noreq"}, dbus_req_valid, 64'd0);
      check({tag, "/wait_ready"}, mem_ready, 64'd0);
      tick();
    end
    dbus_resp_valid = 1'b0;
    dbus_rdata = {$urandom, $urandom};
    #1;
    check({tag, "/done_ready"}, mem_ready, 64'd1);
    check({tag, "/readdata"}, wb_readdata, wr ? 64'd0 : ref_load(rdata, addr, sz, uns));
    tick();
    go_idle();
    #1;
    check({tag, "/after_ready"}, mem_ready, 64'd1);
    check({tag, "/after_noreq"}, dbus_req_valid, 64'd0);
    check({tag, "/after_rdata0"}, wb_readdata, 64'd0);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [63:0] addr, rs2, rdata;
    int          kind;

    rst = 1'b1;
    go_idle();
    mem_size = 2'd0; mem_unsigned = 1'b0; exe_result = 64'd0; exe_rs2 = 64'd0;
    dbus_rdata = 64'd0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("reset/ready", mem_ready, 64'd1);
    check("reset/req_valid", dbus_req_valid, 64'd0);
    check("reset/readdata", wb_readdata, 64'd0);
    check("reset/misalign", mem_misalign, 64'd0);
    check("reset/addr", dbus_addr, 64'd0);

    // Minimum-latency doubleword load: ready in REQ, response in WAIT, retire in DONE.
    run_access("ld", 1'b1, 1'b0, 2'd3, 1'b0, 64'h1000, 64'd0, 64'h8877665544332211, 0, 0);
    run_access("lb", 1'b1, 1'b0, 2'd0, 1'b0, 64'h1007, 64'd0, 64'h80AABBCCDDEEFF11, 0, 0);
    run_access("lbu", 1'b1, 1'b0, 2'd0, 1'b1, 64'h1007, 64'd0, 64'h80AABBCCDDEEFF11, 0, 0);
    run_access("sh", 1'b0, 1'b1, 2'd1, 1'b0, 64'h2002, 64'h000000000000BEEF, 64'd0, 0, 0);
    run_access("lw_mis", 1'b1, 1'b0, 2'd2, 1'b0, 64'h1002, 64'd0, 64'd0, 0, 0);
    run_access("ready_late", 1'b1, 1'b0, 2'd2, 1'b0, 64'h1004, 64'd0, 64'hF00DCAFE87654321, 4, 0);

    // Non-memory instruction.
    present(1'b0, 1'b0, 2'd3, 1'b0, 64'h5555, 64'd0);
    #1;
    check("nomem/ready", mem_ready, 64'd1);
    check("nomem/noreq", dbus_req_valid, 64'd0);
    check("nomem/readdata", wb_readdata, 64'd0);
    tick();
    go_idle();

    // Flush in WAIT, response five cycles late -> drain, then a clean load.
    present(1'b1, 1'b0, 2'd3, 1'b0, 64'h3000, 64'd0);
    tick();
    dbus_req_ready = 1'b1;
    #1;
    check("fw/req_valid", dbus_req_valid, 64'd1);
    tick();
    dbus_req_ready = 1'b0; mem_flush = 1'b1;
    #1;
    check("fw/wait_ready", mem_ready, 64'd0);
    tick();
    go_idle();
    for (int i = 0; i < 4; i++) begin
      dbus_rdata = {$urandom, $urandom};
      #1;
      check("fw/drain_ready", mem_ready, 64'd0);
      check("fw/drain_noreq", dbus_req_valid, 64'd0);
      tick();
    end
    dbus_resp_valid = 1'b1; dbus_rdata = 64'hDEADDEADDEADDEAD;
    #1;
    check("fw/drain_resp_ready", mem_ready, 64'd0);
    tick();
    dbus_resp_valid = 1'b0;
    #1;
    check("fw/idle_ready", mem_ready, 64'd1);
    run_access("fw/next", 1'b1, 1'b0, 2'd3, 1'b0, 64'h3008, 64'd0, 64'h0123456789ABCDEF, 0, 1);

    // Flush in REQ without handshake -> request withdrawn.
    present(1'b1, 1'b0, 2'd2, 1'b0, 64'h4000, 64'd0);
    tick();
    mem_flush = 1'b1;
    #1;
    check("fr/req_valid", dbus_req_valid, 64'd1);
    tick();
    go_idle();
    dbus_req_ready = 1'b1;
    #1;
    check("fr/withdrawn", dbus_req_valid, 64'd0);
    check("fr/ready", mem_ready, 64'd1);
    tick();
    dbus_req_ready = 1'b0;
    #1;
    check("fr/still_idle", dbus_req_valid, 64'd0);

    // Flush coinciding with acceptance -> drain.
    present(1'b0, 1'b1, 2'd3, 1'b0, 64'h4100, 64'h1122334455667788);
    tick();
    mem_flush = 1'b1; dbus_req_ready = 1'b1;
    tick();
    go_idle();
    #1;
    check("fa/drain_ready", mem_ready, 64'd0);
    check("fa/drain_noreq", dbus_req_valid, 64'd0);
    dbus_resp_valid = 1'b1;
    tick();
    dbus_resp_valid = 1'b0;
    #1;
    check("fa/idle_ready", mem_ready, 64'd1);

    // Flush in WAIT with the response in the same cycle -> straight to idle.
    present(1'b1, 1'b0, 2'd3, 1'b0, 64'h4200, 64'd0);
    tick();
    dbus_req_ready = 1'b1;
    tick();
    dbus_req_ready = 1'b0; mem_flush = 1'b1; dbus_resp_valid = 1'b1;
    tick();
    go_idle();
    #1;
    check("fwr/idle_ready", mem_ready, 64'd1);
    check("fwr/readdata", wb_readdata, 64'd0);

    // Flush in DONE still retires that cycle.
    present(1'b1, 1'b0, 2'd3, 1'b0, 64'h4300, 64'd0);
    tick();
    dbus_req_ready = 1'b1;
    tick();
    dbus_req_ready = 1'b0; dbus_resp_valid = 1'b1; dbus_rdata = 64'h0F0E0D0C0B0A0908;
    tick();
    dbus_resp_valid = 1'b0; mem_flush = 1'b1;
    #1;
    check("fd/done_ready", mem_ready, 64'd1);
    tick();
    go_idle();
    #1;
    check("fd/idle_ready", mem_ready, 64'd1);
    check("fd/noreq", dbus_req_valid, 64'd0);

    // Reset in the middle of a request.
    present(1'b1, 1'b0, 2'd3, 1'b0, 64'h4400, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    go_idle();
    #1;
    check("rst_mid/noreq", dbus_req_valid, 64'd0);
    check("rst_mid/ready", mem_ready, 64'd1);

    // Randomized accesses.
    for (int k = 0; k < 60; k++) begin
      kind  = $urandom_range(0, 9);
      sz    = 2'($urandom_range(0, 3));
      rs2   = {$urandom, $urandom};
      rdata = {$urandom, $urandom};
      addr  = {32'h0, $urandom};
      if (kind == 9) begin
        if (sz == 2'd0) sz = 2'd1;
        addr[0] = 1'b1;
      end else begin
        addr = addr & ~((64'd1 << sz) - 64'd1);
      end
      if (kind == 0) begin
        present(1'b0, 1'b0, sz, 1'b0, addr, rs2);
        #1;
        check("rnd/nomem_ready", mem_ready, 64'd1);
        check("rnd/nomem_noreq", dbus_req_valid, 64'd0);
        tick();
        go_idle();
      end else begin
        run_access("rnd", (kind < 5) || (kind == 9), (kind >= 5) && (kind < 9), sz,
                   1'($urandom_range(0, 1)), addr, rs2, rdata,
                   $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_mem.md
STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 clk  in  1  sole clock, rising edge.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 mem_flush  in  1  discard the current instruction.
REQ-004 mem_valid  in  1  instruction present in the stage.
REQ-005 mem_read / mem_write  in  1 each  load / store control; never both set.
REQ-006 mem_size  in  2  0=B, 1=H, 2=W, 3=D.
REQ-007 mem_unsigned  in  1  zero-extend load data when set.
REQ-008 exe_result  in  64  ALU result / effective address.
REQ-009 exe_rs2  in  64  store data.
REQ-010 mem_ready  out  1  stage can retire the instruction this cycle.
REQ-011 mem_misalign  out  1  access not naturally aligned.
REQ-012 wb_result  out  64  exe_result passed through.
REQ-013 wb_readdata  out  64  aligned, extended load data.
REQ-014 dbus_req_valid  out  1;  dbus_req_ready  in  1  request handshake.
REQ-015 dbus_addr  out  64  exe_result with bits [2:0] cleared.
REQ-016 dbus_we  out  1;  dbus_wstrb  out  8;  dbus_wdata  out  64  write controls.
REQ-017 dbus_resp_valid  in  1;  dbus_rdata  in  64  response, one per accepted request (loads and stores).

Function
REQ-018 FSM states: IDLE, REQ, WAIT, DONE, DRAIN.
REQ-019 IDLE, no access (mem_valid=0, or neither read nor write): mem_ready=1 combinationally; no bus activity.
REQ-020 Misaligned access (H with addr[0]!=0, W with addr[1:0]!=0, D with addr[2:0]!=0): mem_misalign=1 and mem_ready=1 combinationally; no request issued; state stays IDLE.
REQ-021 IDLE, aligned access, no flush: next state REQ; mem_ready=0.
REQ-022 REQ: dbus_req_valid=1 with addr/we/wstrb/wdata held stable; on dbus_req_ready go WAIT.
REQ-023 WAIT: on dbus_resp_valid, capture dbus_rdata into a 64-bit register and go DONE.
REQ-024 DONE: mem_ready=1 for exactly one cycle, wb_readdata driven from the captured register; next state IDLE.
REQ-025 Minimum latency for an aligned access, with bus ready and response in the cycle after acceptance: 3 cycles from entering REQ to mem_ready.
REQ-026 dbus_wstrb: mask of 2^mem_size ones, shifted left by addr[2:0].
REQ-027 dbus_wdata: exe_rs2 shifted left by 8*addr[2:0].
REQ-028 Load extraction: shift dbus_rdata right by 8*addr[2:0]; take the low 8/16/32/64 bits; sign- or zero-extend per mem_unsigned (D ignores mem_unsigned).
REQ-029 wb_readdata=0 for any store or non-memory instruction.
REQ-030 Flush in IDLE or REQ (before handshake completes): next state IDLE; no request is accepted afterward.
REQ-031 Flush in the same cycle as dbus_req_ready in REQ: the request counts as accepted; next state DRAIN.
REQ-032 Flush in WAIT: go DRAIN, or IDLE if dbus_resp_valid is high that cycle; the response is discarded.
REQ-033 Flush in DONE: go IDLE; mem_ready is still asserted that cycle.
REQ-034 DRAIN: mem_ready=0; on dbus_resp_valid go IDLE and discard the data.
REQ-035 Flush never causes a second outstanding request; at most one request is in flight.
REQ-036 Latch address, size, unsigned, and write data on leaving IDLE; use the latched copies through DONE.

Reset
REQ-037 rst: state IDLE; captured data=0; latched controls=0; dbus_req_valid=0.
REQ-038 Reset mid-transaction abandons any outstanding response; the bus is reset together with this stage.

Structure
REQ-039 The FSM state enum, the size encoding, and the mem-to-wb struct (result, readdata) belong in the shared common package.
REQ-040 The load extract/extend logic is one sub-module, load_align (rdata, offset, size, unsigned -> 64-bit result); store strobe/data generation stays inline.

Verification
REQ-041 LD, addr 0x1000, rdata 0x8877665544332211, ready=1, response next cycle -> mem_ready 3 cycles after REQ; wb_readdata 0x8877665544332211.
REQ-042 LB, addr 0x1007, rdata 0x80xx..xx -> wb_readdata 0xFFFFFFFFFFFFFF80; LBU -> 0x0000000000000080.
REQ-043 SH, addr 0x2002, rs2 0xBEEF -> dbus_wstrb 0x0C, dbus_wdata[31:16]=0xBEEF, dbus_addr 0x2000, dbus_we=1.
REQ-044 LW, addr 0x1002 -> mem_misalign=1, mem_ready=1 same cycle, dbus_req_valid never asserted.
REQ-045 Flush in WAIT with response delayed 5 cycles -> DRAIN, mem_ready=0 until response, then IDLE; the next load returns its own data.
REQ-046 dbus_req_ready held low 4 cycles -> dbus_req_valid and address stable throughout; request accepted once ready rises.
